// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32x32 multiply / divide unit with HI/LO result registers.
// One operation at a time. Each one takes 32 RUN iterations plus a FIX cycle
// that applies the sign correction and writes HI/LO. Multiply uses shift-add on
// a 64-bit accumulator. Divide uses restoring shift-subtract on the same
// accumulator, with the remainder in the upper half and the quotient in the
// lower half.
//
// Handshake: start is sampled on a rising edge only while IDLE (busy=0).
// - A start seen while busy is dropped, and nothing is queued.
// - done is a one-cycle pulse that follows the FIX cycle.
// - start may be asserted in the done cycle, because the unit is IDLE then.
// - mthi/mtlo are honoured only in IDLE with start=0.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  input  logic        mthi,
  input  logic        mtlo,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  state_t      state;
  state_t      state_next;
  logic [5:0]  cnt;
  logic        is_mul_q;
  logic        sign_a_q;
  logic        sign_b_q;
  logic        b_zero_q;
  logic [31:0] opnd_q;    // multiplicand (multiply) or divisor (divide), as a magnitude
  logic [63:0] acc;

  // Operand conditioning at launch: magnitudes for signed ops, raw for unsigned ops.
  logic        op_signed;
  logic        op_is_mul;
  logic        sa_in;
  logic        sb_in;
  logic [31:0] mag_a;
  logic [31:0] mag_b;

  // Per-iteration datapath.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_sh;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [63:0] div_next;

  // Sign-corrected results written during FIX.
  logic [63:0] prod_fix;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  // Unused op encodings are named here so the decode below reads clearly.
  logic        unused_ops;
  assign unused_ops = (op == OP_MULTU) | (op == OP_DIVU);

  assign busy = (state != S_IDLE);

  // Decode the launch operands: op[0]=0 selects the signed variants.
  always_comb begin
    op_signed = (op == OP_MULT) || (op == OP_DIV);
    op_is_mul = ~op[1];
    sa_in     = op_signed & srca[31];
    sb_in     = op_signed & srcb[31];
    mag_a     = sa_in ? (32'd0 - srca) : srca;
    mag_b     = sb_in ? (32'd0 - srcb) : srcb;
  end

  // One multiply step (shift-add) and one divide step (restoring, 33-bit compare).
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd_q} : 33'd0);
    mul_next = {mul_sum, acc[31:1]};
    div_sh   = {acc[63:32], acc[31]};
    div_ge   = (div_sh >= {1'b0, opnd_q});
    div_diff = div_sh[31:0] - opnd_q;
    div_next = {(div_ge ? div_diff : div_sh[31:0]), acc[30:0], div_ge};
  end

  // Final sign correction. A zero divisor bypasses it so the result is LO=all ones, HI=srca.
  always_comb begin
    prod_fix = (sign_a_q ^ sign_b_q) ? (64'd0 - acc) : acc;
    if (b_zero_q) begin
      quot_fix = 32'hFFFF_FFFF;
    end else begin
      quot_fix = (sign_a_q ^ sign_b_q) ? (32'd0 - acc[31:0]) : acc[31:0];
    end
    rem_fix = sign_a_q ? (32'd0 - acc[63:32]) : acc[63:32];
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state: IDLE -> RUN on start, RUN for 32 iterations, then one FIX cycle.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if (cnt == 6'd31) state_next = S_FIX;
      S_FIX:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, result write-back, moves and the done flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= 6'd0;
      is_mul_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      b_zero_q <= 1'b0;
      opnd_q   <= 32'd0;
      acc      <= 64'd0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt      <= 6'd0;
            is_mul_q <= op_is_mul;
            sign_a_q <= sa_in;
            sign_b_q <= sb_in;
            b_zero_q <= (srcb == 32'd0);
            if (op_is_mul) begin
              opnd_q <= mag_a;
              acc    <= {32'd0, mag_b};
            end else begin
              opnd_q <= mag_b;
              acc    <= {32'd0, mag_a};
            end
          end else begin
            if (mthi) hi <= srca;
            if (mtlo) lo <= srca;
          end
        end
        S_RUN: begin
          cnt <= cnt + 6'd1;
          acc <= is_mul_q ? mul_next : div_next;
        end
        S_FIX: begin
          done <= 1'b1;
          if (is_mul_q) begin
            hi <= prod_fix[63:32];
            lo <= prod_fix[31:0];
          end else begin
            hi <= rem_fix;
            lo <= quot_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001: No parameters; all datapath widths SHALL be fixed at 32 bits.
REQ-002: clk  input  1  rising-edge clock for all state.
REQ-003: reset  input  1  asynchronous, active-high reset.
REQ-004: start  input  1  request to launch an operation; sampled on the rising edge of clk.
REQ-005: op  input  2  operation select: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006: srca  input  32  multiplicand or dividend (rs).
REQ-007: srcb  input  32  multiplier or divisor (rt).
REQ-008: mthi  input  1  write srca into HI.
REQ-009: mtlo  input  1  write srca into LO.
REQ-010: busy  output  1  high while an operation is in flight.
REQ-011: done  output  1  one-cycle pulse; HI and LO hold the new result.
REQ-012: hi  output  32  HI register (product[63:32] or remainder).
REQ-013: lo  output  32  LO register (product[31:0] or quotient).

Function
REQ-014: FSM states SHALL be IDLE, RUN and FIX; the DONE pulse is a registered flag, not a state.
REQ-015: IDLE: on start=1, the unit SHALL capture op, |srca|, |srcb| (magnitudes for signed ops; raw for unsigned ops) and both sign bits, clear the 6-bit iteration counter, and go to RUN.
REQ-016: RUN SHALL perform exactly one iteration per cycle for 32 cycles, then go to FIX.
  - Multiply iteration: shift-add on a 64-bit accumulator.
  - Divide iteration: restoring shift-subtract; the 32-bit remainder is extended by 1 bit for the compare.
REQ-017: FIX SHALL last one cycle, apply the sign correction, write HI/LO, and return to IDLE.
REQ-018: Latency: with start sampled at edge k, busy SHALL be 1 in cycles k+1..k+33 (33 cycles); HI/LO SHALL update at edge k+33; done SHALL be 1 for cycle k+34 only.
REQ-019: MULT sign correction: the 64-bit product SHALL be two's-complement negated when the operand signs differ; MULTU SHALL never negate.
REQ-020: DIV sign correction: the quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the sign of the dividend; DIVU SHALL never negate.
REQ-021: Divide by zero SHALL take the full 33-cycle latency and yield LO=0xFFFFFFFF and HI=original srca, for both DIV and DIVU.
REQ-022: DIV of 0x80000000 by 0xFFFFFFFF SHALL yield LO=0x80000000 and HI=0x00000000.
REQ-023: Changes to srca, srcb or op while busy=1 SHALL NOT affect the result.
REQ-024: start while busy=1 SHALL be ignored, with no queuing.
REQ-025: start in the same cycle as done=1 SHALL be accepted; that cycle is IDLE.
REQ-026: mthi/mtlo SHALL write HI/LO at the next edge only when in IDLE and start=0.
  - If start=1 in the same cycle, start SHALL win and the move SHALL be dropped.
  - While busy=1, moves SHALL be ignored.
REQ-027: mthi and mtlo asserted together SHALL write srca into both registers.
REQ-028: HI/LO SHALL hold their values except when written by FIX or by a move.
REQ-029: Until FIX, only internal accumulators SHALL change; HI/LO SHALL keep their old values throughout RUN.

Reset
REQ-030: reset=1 SHALL asynchronously force state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0 and clear the accumulators.
REQ-031: Reset during RUN or FIX SHALL abort the operation with no HI/LO write and no done pulse.
REQ-032: After reset deasserts, the first start SHALL behave exactly as from power-up IDLE.

Verification
REQ-033: MULT srca=0xFFFFFFFE, srcb=0x00000003 -> busy for 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, with done for exactly one cycle.
REQ-034: MULTU srca=0xFFFFFFFF, srcb=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-035: DIV srca=0xFFFFFFF9 (-7), srcb=0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 -> lo=0x0000000E, hi=0x00000002.
REQ-036: DIVU srca=0x00000064, srcb=0 -> after 33 busy cycles, lo=0xFFFFFFFF, hi=0x00000064.
REQ-037: During a MULT, pulse start (different op) and mtlo=1 at RUN cycle 5 -> both ignored, and the original MULT result is written.
REQ-038: Assert reset at RUN cycle 10 -> busy=0, hi=lo=0 immediately, no done; a new start after release completes normally in 33 cycles.
